// File: rtl/vrf_pkg.sv
// -----------------------------------------------------------------------------
// vrf_pkg
// Shared constants and types for the vector register file write-back path.
//   VREG_COUNT / VREG_AW / VLANES : register count, address width, lane count
//   vreg_addr_t                   : register address type
//   vrf_wb_state_e                : controller state (CLEAR / RUN)
//   addr_onehot()                 : register address -> one-hot register mask
// -----------------------------------------------------------------------------
package vrf_pkg;

    localparam int VREG_COUNT = 16;
    localparam int VREG_AW    = 4;
    localparam int VLANES     = 16;

    typedef logic [VREG_AW-1:0] vreg_addr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } vrf_wb_state_e;

    // One-hot mask with the bit of register 'a' set.
    function automatic logic [VREG_COUNT-1:0] addr_onehot(input vreg_addr_t a);
        logic [VREG_COUNT-1:0] v;
        v    = {VREG_COUNT{1'b0}};
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/vrf_wb_ctrl_if.sv
// -----------------------------------------------------------------------------
// vrf_wb_ctrl_if
// Bundles the write-back request channels, the decode issue/stall channel and
// the register-file write port of vrf_wb_ctrl.
//   alu_* / ld_*  : write-back requests (valid/ready/addr/data)
//   iss_*         : decode operand/destination info and the stall answer
//   rf_*          : register file write port (we3/ra3/wd3)
//   init_done     : controller is in RUN
// Modports: slave = controller side, master = surrounding pipeline side.
// -----------------------------------------------------------------------------
interface vrf_wb_ctrl_if #(
    parameter int N = 16
);
    import vrf_pkg::*;

    logic                     alu_valid;
    logic                     alu_ready;
    vreg_addr_t               alu_addr;
    logic [VLANES-1:0][N-1:0] alu_data;

    logic                     ld_valid;
    logic                     ld_ready;
    vreg_addr_t               ld_addr;
    logic [VLANES-1:0][N-1:0] ld_data;

    logic                     iss_valid;
    vreg_addr_t               iss_rs1;
    vreg_addr_t               iss_rs2;
    vreg_addr_t               iss_rd;
    logic                     iss_use1;
    logic                     iss_use2;
    logic                     iss_we;
    logic                     iss_stall;

    logic                     rf_we;
    vreg_addr_t               rf_wa;
    logic [VLANES-1:0][N-1:0] rf_wd;
    logic                     init_done;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_use1, iss_use2, iss_we,
        output alu_ready, ld_ready, iss_stall,
        output rf_we, rf_wa, rf_wd, init_done
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_use1, iss_use2, iss_we,
        input  alu_ready, ld_ready, iss_stall,
        input  rf_we, rf_wa, rf_wd, init_done
    );

endinterface

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone requester is granted; on a tie the
// requester that did not win most recently is granted. 'last' remembers the
// index of the most recent winner and resets to 1 so index 0 wins the first tie.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : allows 'last' to update on a grant
//   req[1:0]   : requests
//   gnt[1:0]   : one-hot (or zero) grant, combinational
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // Grant selection from the current requests and the previous winner.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner whenever a grant is issued while enabled.
    always_comb begin
        if (en && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end else begin
            last_d = last_q;
        end
    end

    // Previous-winner register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vrf_wb_ctrl.sv
// -----------------------------------------------------------------------------
// vrf_wb_ctrl
// Write-back controller for the vector register file. Arbitrates the single
// write port between the vector ALU and the load unit, drives the register
// file write port through an output register, and tracks pending writes so
// decode stalls on RAW/WAW hazards.
// Optional feature macro: VRF_CLEAR_EN -- when defined, every reset is
// followed by a 16-cycle sequence that writes zero to all registers before the
// controller enters RUN; when undefined the controller resets straight into RUN.
//   clk    : clock
//   reset  : asynchronous active-low reset
//   bus    : vrf_wb_ctrl_if.slave (requests, issue/stall, RF write port)
// -----------------------------------------------------------------------------
module vrf_wb_ctrl
    import vrf_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    vrf_wb_ctrl_if.slave bus
);

    localparam vreg_addr_t LAST_REG = vreg_addr_t'(VREG_COUNT - 1);

    logic                     run_s;
    logic [1:0]               req_s;
    logic [1:0]               gnt_s;
    logic                     xfer_s;
    vreg_addr_t               wr_addr_s;
    logic [VLANES-1:0][N-1:0] wr_data_s;
    logic                     stall_s;
    logic                     iss_accept_s;
    logic [VREG_COUNT-1:0]    set_mask_s;
    logic [VREG_COUNT-1:0]    clr_mask_s;
    logic [VREG_COUNT-1:0]    pending_d;
    logic [VREG_COUNT-1:0]    pending_q;

    logic                     rf_we_q;
    vreg_addr_t               rf_wa_q;
    logic [VLANES-1:0][N-1:0] rf_wd_q;

`ifdef VRF_CLEAR_EN
    vrf_wb_state_e            state_q;
    vreg_addr_t               cnt_q;

    assign run_s = (state_q == RUN);
`else
    assign run_s = 1'b1;
`endif

    // Requests are masked off while clearing so nobody is granted and the
    // arbiter history stays untouched.
    assign req_s = {bus.ld_valid, bus.alu_valid} & {2{run_s}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (reset),
        .en    (run_s),
        .req   (req_s),
        .gnt   (gnt_s)
    );

    assign bus.alu_ready = gnt_s[0];
    assign bus.ld_ready  = gnt_s[1];
    assign bus.iss_stall = stall_s;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_wa     = rf_wa_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.init_done = run_s;

    // Write-port source selection from the arbiter grant.
    always_comb begin
        xfer_s = (bus.alu_valid & gnt_s[0]) | (bus.ld_valid & gnt_s[1]);
        if (gnt_s[1]) begin
            wr_addr_s = bus.ld_addr;
            wr_data_s = bus.ld_data;
        end else begin
            wr_addr_s = bus.alu_addr;
            wr_data_s = bus.alu_data;
        end
    end

    // Hazard detection and scoreboard next state; a set on the same edge as a
    // clear of the same register wins because the set mask is OR-ed in last.
    always_comb begin
        stall_s = ~run_s
                | (bus.iss_use1 & pending_q[bus.iss_rs1])
                | (bus.iss_use2 & pending_q[bus.iss_rs2])
                | (bus.iss_we   & pending_q[bus.iss_rd]);
        iss_accept_s = bus.iss_valid & ~stall_s;
        if (iss_accept_s && bus.iss_we) begin
            set_mask_s = addr_onehot(bus.iss_rd);
        end else begin
            set_mask_s = {VREG_COUNT{1'b0}};
        end
        if (xfer_s) begin
            clr_mask_s = addr_onehot(wr_addr_s);
        end else begin
            clr_mask_s = {VREG_COUNT{1'b0}};
        end
        pending_d = (pending_q & ~clr_mask_s) | set_mask_s;
    end

    // Controller state, clear counter, write-port output register and scoreboard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q   <= 1'b0;
            rf_wa_q   <= {VREG_AW{1'b0}};
            rf_wd_q   <= {(VLANES*N){1'b0}};
            pending_q <= {VREG_COUNT{1'b0}};
`ifdef VRF_CLEAR_EN
            state_q   <= CLEAR;
            cnt_q     <= {VREG_AW{1'b0}};
`endif
        end else begin
            pending_q <= pending_d;
`ifdef VRF_CLEAR_EN
            if (state_q == CLEAR) begin
                rf_we_q <= 1'b1;
                rf_wa_q <= cnt_q;
                rf_wd_q <= {(VLANES*N){1'b0}};
                cnt_q   <= cnt_q + 4'd1;
                if (cnt_q == LAST_REG) begin
                    state_q <= RUN;
                end else begin
                    state_q <= CLEAR;
                end
            end else begin
`else
            begin
`endif
                rf_we_q <= xfer_s;
                if (xfer_s) begin
                    rf_wa_q <= wr_addr_s;
                    rf_wd_q <= wr_data_s;
                end else begin
                    rf_wa_q <= rf_wa_q;
                    rf_wd_q <= rf_wd_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_vrf_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vrf_wb_ctrl
// Self-checking bench for vrf_wb_ctrl: a behavioural model (pending set,
// previous winner, clear progress) predicts every output each cycle, plus
// directed scenarios with literal expectations.
// -----------------------------------------------------------------------------
module tb_vrf_wb_ctrl;
    import vrf_pkg::*;

    localparam int N = 16;
    localparam int W = VLANES * N;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vrf_wb_ctrl_if #(.N(N)) bus ();

    vrf_wb_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    bit             m_pend [VREG_COUNT];
    int             m_prev;        // index of most recent winner: 0 ALU, 1 LD
    bit             m_we;
    int             m_wa;
    logic [W-1:0]   m_wd;
    int             m_clear_left;
    int             m_clear_next;
    bit             m_init;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_wd(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] v;
        for (int l = 0; l < VLANES; l++) v[l*N +: N] = N'($urandom);
        return v;
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_prev       = 1;
        m_we         = 1'b0;
        m_wa         = 0;
        m_wd         = '0;
        m_clear_next = 0;
`ifdef VRF_CLEAR_EN
        m_clear_left = 16;
        m_init       = 1'b0;
`else
        m_clear_left = 0;
        m_init       = 1'b1;
`endif
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_addr = 4'd0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_addr  = 4'd0; bus.ld_data  = '0;
        bus.iss_valid = 1'b0; bus.iss_rs1 = 4'd0; bus.iss_rs2 = 4'd0; bus.iss_rd = 4'd0;
        bus.iss_use1  = 1'b0; bus.iss_use2 = 1'b0; bus.iss_we = 1'b0;
    endtask

    // One clock: compare mid-cycle against the model, then advance the model.
    task automatic step();
        bit e_ar, e_lr, e_st;
        @(negedge clk);
        e_ar = m_init && bus.alu_valid && (!bus.ld_valid || m_prev == 1);
        e_lr = m_init && bus.ld_valid && (!bus.alu_valid || m_prev == 0);
        e_st = !m_init || (bus.iss_use1 && m_pend[bus.iss_rs1])
                       || (bus.iss_use2 && m_pend[bus.iss_rs2])
                       || (bus.iss_we   && m_pend[bus.iss_rd]);
        chk("alu_ready", 32'(bus.alu_ready), 32'(e_ar));
        chk("ld_ready",  32'(bus.ld_ready),  32'(e_lr));
        chk("iss_stall", 32'(bus.iss_stall), 32'(e_st));
        chk("rf_we",     32'(bus.rf_we),     32'(m_we));
        chk("rf_wa",     32'(bus.rf_wa),     m_wa);
        chk_wd("rf_wd",  bus.rf_wd,          m_wd);
        chk("init_done", 32'(bus.init_done), 32'(m_init));
        @(posedge clk);
        if (!m_init) begin
            m_we = 1'b1; m_wa = m_clear_next; m_wd = '0;
            m_clear_next++; m_clear_left--;
            if (m_clear_left == 0) m_init = 1'b1;
        end else begin
            if (e_ar) begin
                m_we = 1'b1; m_wa = int'(bus.alu_addr); m_wd = bus.alu_data;
                m_prev = 0; m_pend[m_wa] = 1'b0;
            end else if (e_lr) begin
                m_we = 1'b1; m_wa = int'(bus.ld_addr); m_wd = bus.ld_data;
                m_prev = 1; m_pend[m_wa] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (bus.iss_valid && !e_st && bus.iss_we) m_pend[bus.iss_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b0;
        model_reset();
        #2;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_wa", 32'(bus.rf_wa), 32'd0);
        chk_wd("rst_rf_wd", bus.rf_wd, {W{1'b0}});
`ifdef VRF_CLEAR_EN
        chk("rst_init", 32'(bus.init_done), 32'd0);
`else
        chk("rst_init", 32'(bus.init_done), 32'd1);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic settle_clear();
`ifdef VRF_CLEAR_EN
        repeat (16) step();
`endif
    endtask

    initial begin
        logic [W-1:0] a5;
        a5 = {VLANES{16'hA5A5}};

        // Reset and the zero-clear sequence with literal expectations.
        apply_reset();
`ifdef VRF_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            chk("clr_stall_lit", 32'(bus.iss_stall), 32'd1);
            step();
            chk("clr_we_lit",   32'(bus.rf_we), 32'd1);
            chk("clr_wa_lit",   32'(bus.rf_wa), i);
            chk_wd("clr_wd_lit", bus.rf_wd, {W{1'b0}});
            chk("clr_init_lit", 32'(bus.init_done), (i == 15) ? 32'd1 : 32'd0);
        end
`endif

        // Single ALU write to register 5.
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = a5;
        #1;
        chk("alu5_ready_lit", 32'(bus.alu_ready), 32'd1);
        step();
        idle();
        chk("alu5_we_lit", 32'(bus.rf_we), 32'd1);
        chk("alu5_wa_lit", 32'(bus.rf_wa), 32'd5);
        chk_wd("alu5_wd_lit", bus.rf_wd, a5);
        step();

        // Contention from a fresh reset: ALU, LD, ALU, LD.
        apply_reset();
        settle_clear();
        for (int k = 0; k < 4; k++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = rnd_data();
            bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd7; bus.ld_data  = rnd_data();
            #1;
            chk("rr_alu_lit", 32'(bus.alu_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ld_lit",  32'(bus.ld_ready),  (k % 2 == 0) ? 32'd0 : 32'd1);
            step();
            chk("rr_wa_lit", 32'(bus.rf_wa), (k % 2 == 0) ? 32'd3 : 32'd7);
        end
        idle();
        step();

        // RAW hazard on register 9.
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd9; bus.iss_we = 1'b1;
        #1;
        chk("raw_issue_lit", 32'(bus.iss_stall), 32'd0);
        step();
        bus.iss_we = 1'b0; bus.iss_rd = 4'd0; bus.iss_rs1 = 4'd9; bus.iss_use1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("raw_stall_lit", 32'(bus.iss_stall), 32'd1);
            step();
        end
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd9; bus.alu_data = rnd_data();
        #1;
        chk("raw_grant_stall_lit", 32'(bus.iss_stall), 32'd1);
        step();
        bus.alu_valid = 1'b0;
        #1;
        chk("raw_release_lit", 32'(bus.iss_stall), 32'd0);
        step();
        idle();

        // Set and clear of register 4 on the same edge: set wins.
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd4; bus.iss_we = 1'b1;
        bus.ld_valid  = 1'b1; bus.ld_addr = 4'd4; bus.ld_data = rnd_data();
        #1;
        chk("sw_ld_ready_lit", 32'(bus.ld_ready), 32'd1);
        chk("sw_accept_lit",   32'(bus.iss_stall), 32'd0);
        step();
        idle();
        bus.iss_rs1 = 4'd4; bus.iss_use1 = 1'b1;
        #1;
        chk("sw_pending_lit", 32'(bus.iss_stall), 32'd1);
        step();
        idle();
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd4; bus.alu_data = rnd_data();
        step();
        idle();
        step();

        // Randomized traffic against the model, with one reset in the middle.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                apply_reset();
                settle_clear();
            end
            bus.alu_valid = 1'($urandom_range(0, 1));
            bus.alu_addr  = 4'($urandom);
            bus.alu_data  = rnd_data();
            bus.ld_valid  = 1'($urandom_range(0, 1));
            bus.ld_addr   = 4'($urandom);
            bus.ld_data   = rnd_data();
            bus.iss_valid = 1'($urandom_range(0, 1));
            bus.iss_rs1   = 4'($urandom);
            bus.iss_rs2   = 4'($urandom);
            bus.iss_rd    = 4'($urandom);
            bus.iss_use1  = 1'($urandom_range(0, 1));
            bus.iss_use2  = 1'($urandom_range(0, 1));
            bus.iss_we    = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        step();

`ifdef VRF_CLEAR_EN
        // Reset in the middle of the clear sequence restarts it at register 0.
        apply_reset();
        repeat (8) step();
        reset = 1'b0;
        #1;
        chk("midclr_we_lit",   32'(bus.rf_we), 32'd0);
        chk("midclr_wa_lit",   32'(bus.rf_wa), 32'd0);
        chk("midclr_init_lit", 32'(bus.init_done), 32'd0);
        apply_reset();
        step();
        chk("restart_we_lit", 32'(bus.rf_we), 32'd1);
        chk("restart_wa_lit", 32'(bus.rf_wa), 32'd0);
        repeat (15) step();
        chk("restart_init_lit", 32'(bus.init_done), 32'd1);
`else
        // Reset discards pending writes.
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd2; bus.iss_we = 1'b1;
        step();
        idle();
        bus.iss_rs1 = 4'd2; bus.iss_use1 = 1'b1;
        #1;
        chk("pend2_lit", 32'(bus.iss_stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("pend2_reset_lit", 32'(bus.iss_stall), 32'd0);
        apply_reset();
        bus.iss_rs1 = 4'd2; bus.iss_use1 = 1'b1;
        step();
`endif
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
